// File: rtl/parking_gate_arbiter.sv
// ---------------------------------------------------------------------------
// parking_gate_arbiter
//
// Arbitrates a single parking gate between entry and exit requests for a
// four-slot lot. Requests arrive as one-cycle pulses, are held pending until
// the gate is idle, and are then granted (door opens for HOLD_CYCLES cycles)
// or rejected (lot full on entry, slot already empty on exit).
//
// Ports
//   CLK          rising-edge clock
//   RST          synchronous, active-high reset
//   enter        entry request pulse
//   exit         exit request pulse
//   switch[1:0]  slot being vacated, sampled together with exit
//   door_open    gate open (OPEN_IN / OPEN_OUT)
//   grant_enter  one-cycle entry grant pulse
//   grant_exit   one-cycle exit grant pulse
//   reject_enter one-cycle entry rejection pulse
//   reject_exit  one-cycle exit rejection pulse
//   L[1:0]       slot assigned by last entry grant / freed by last exit grant
//   occupancy    bit i set = slot i occupied
//   capacity     number of free slots (0..4)
//   full         all slots occupied
//   busy         FSM not in IDLE
// ---------------------------------------------------------------------------
module parking_gate_arbiter #(
    parameter int NSLOTS      = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enter,
    input  logic       exit,
    input  logic [1:0] switch,
    output logic       door_open,
    output logic       grant_enter,
    output logic       grant_exit,
    output logic       reject_enter,
    output logic       reject_exit,
    output logic [1:0] L,
    output logic [3:0] occupancy,
    output logic [2:0] capacity,
    output logic       full,
    output logic       busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] OPEN_IN  = 2'd1;
    localparam logic [1:0] OPEN_OUT = 2'd2;
    localparam logic [1:0] CLOSE    = 2'd3;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] timer;
    logic       pend_in;
    logic       pend_out;
    logic [1:0] ex_slot;
    // Set when the most recent grant was an exit; the other direction then
    // wins a tie. Cleared by reset so that exit wins the first tie.
    logic       last_was_exit;

    logic       valid_in;
    logic       valid_out;
    logic       do_in;
    logic       do_out;
    logic       do_rej_in;
    logic       do_rej_out;
    logic [1:0] free_slot;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [1:0] lowest_free(input logic [3:0] v);
        logic [1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) r = 2'(i);
        end
        return r;
    endfunction

    assign full      = &occupancy;
    assign capacity  = 3'(NSLOTS) - popcount4(occupancy);
    assign busy      = (state != IDLE);
    assign door_open = (state == OPEN_IN) || (state == OPEN_OUT);
    assign free_slot = lowest_free(occupancy);

    // IDLE decision. An invalid exit is dropped on its own cycle before
    // anything else is considered; an invalid entry is only dropped when no
    // exit is pending, so a full lot keeps the entry waiting behind an exit.
    always_comb begin
        valid_in   = !full;
        valid_out  = occupancy[ex_slot];
        do_rej_out = pend_out && !valid_out;
        do_out     = pend_out && valid_out && !(pend_in && valid_in && last_was_exit);
        do_in      = pend_in && valid_in && !do_rej_out &&
                     (!(pend_out && valid_out) || last_was_exit);
        do_rej_in  = pend_in && !valid_in && !pend_out;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            timer         <= '0;
            pend_in       <= 1'b0;
            pend_out      <= 1'b0;
            ex_slot       <= '0;
            last_was_exit <= 1'b0;
            occupancy     <= '0;
            L             <= '0;
            grant_enter   <= 1'b0;
            grant_exit    <= 1'b0;
            reject_enter  <= 1'b0;
            reject_exit   <= 1'b0;
        end else begin
            grant_enter  <= 1'b0;
            grant_exit   <= 1'b0;
            reject_enter <= 1'b0;
            reject_exit  <= 1'b0;

            // Capture is independent of state; a repeat pulse while pending
            // is ignored and the first ex_slot is kept.
            if (enter && !pend_in) pend_in <= 1'b1;
            if (exit && !pend_out) begin
                pend_out <= 1'b1;
                ex_slot  <= switch;
            end

            case (state)
                IDLE: begin
                    if (do_rej_out) begin
                        reject_exit <= 1'b1;
                        pend_out    <= 1'b0;
                    end else if (do_out) begin
                        state                <= OPEN_OUT;
                        grant_exit           <= 1'b1;
                        L                    <= ex_slot;
                        occupancy[ex_slot]   <= 1'b0;
                        pend_out             <= 1'b0;
                        timer                <= HOLD_LOAD;
                        last_was_exit        <= 1'b1;
                    end else if (do_in) begin
                        state                <= OPEN_IN;
                        grant_enter          <= 1'b1;
                        L                    <= free_slot;
                        occupancy[free_slot] <= 1'b1;
                        pend_in              <= 1'b0;
                        timer                <= HOLD_LOAD;
                        last_was_exit        <= 1'b0;
                    end else if (do_rej_in) begin
                        reject_enter <= 1'b1;
                        pend_in      <= 1'b0;
                    end
                end
                OPEN_IN, OPEN_OUT: begin
                    if (timer == 4'd0) begin
                        state <= CLOSE;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/parking_gate_arbiter.md
PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameters: NSLOTS, 4, number of parking slots (fixed 4 in this revision); HOLD_CYCLES, 4, cycles the door stays open per grant (range 1..15).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 enter  input  1  single-cycle entry request pulse.
REQ-005 exit  input  1  single-cycle exit request pulse.
REQ-006 switch  input  2  slot index being vacated; sampled with exit.
REQ-007 door_open  output  1  high while the gate is open.
REQ-008 grant_enter, grant_exit  output  1 each  one-cycle grant pulses.
REQ-009 reject_enter, reject_exit  output  1 each  one-cycle rejection pulses.
REQ-010 L  output  2  slot assigned by last entry grant, or slot freed by last exit grant.
REQ-011 occupancy  output  4  bit i = slot i occupied.
REQ-012 capacity  output  3  free slots, NSLOTS minus popcount(occupancy), range 0..4.
REQ-013 full  output  1  high when occupancy == 4'b1111.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, OPEN_IN, OPEN_OUT, CLOSE; the gate serves one request at a time.
REQ-016 Request capture: enter pulse sets pend_in; exit pulse sets pend_out and latches switch into ex_slot; captured at the edge where the pulse is high, in any state.
REQ-017 A second pulse while its pending flag is already set is ignored; ex_slot keeps its first value.
REQ-018 Validity in IDLE: pend_in valid iff !full; pend_out valid iff occupancy[ex_slot] == 1.
REQ-019 Exit priority: when both are pending and both valid, the direction not served last wins; after reset exit has priority.
REQ-020 If pend_in is pending with full and a valid pend_out is pending, serve the exit; pend_in stays pending and is re-evaluated in the next IDLE.
REQ-021 In IDLE, an invalid pend_out is dropped with reject_exit for one cycle; no state change; occupancy unchanged.
REQ-022 In IDLE, an invalid pend_in with no valid pend_out is dropped with reject_enter for one cycle.
REQ-023 Entry grant edge: state<=OPEN_IN; grant_enter=1; L<=lowest-index free slot; that occupancy bit set; pend_in cleared; timer<=HOLD_CYCLES-1.
REQ-024 Exit grant edge: state<=OPEN_OUT; grant_exit=1; L<=ex_slot; occupancy[ex_slot] cleared; pend_out cleared; timer loaded as in REQ-023.
REQ-025 OPEN_IN/OPEN_OUT: door_open=1; timer decrements each cycle; at timer==0 go to CLOSE; door_open is high for exactly HOLD_CYCLES cycles.
REQ-026 CLOSE: door_open=0 for one cycle, then IDLE.
REQ-027 Latency: pulse sampled at edge N with gate IDLE and no competitor -> grant and door_open from edge N+1; IDLE again at edge N+HOLD_CYCLES+2.
REQ-028 capacity and full are combinational from registered occupancy; they update in the grant cycle.
REQ-029 Occupancy never underflows or overflows; grants occur only for valid requests.

Reset
REQ-030 Reset overrides everything, including mid-open: state IDLE, occupancy 0, capacity 4, full 0, door_open 0, L 0, busy 0.
REQ-031 Reset also clears all grant and reject pulses, pend_in, pend_out, ex_slot and timer, and gives exit priority.
REQ-032 A request pulse coincident with RST is discarded.

Verification
REQ-033 Reset, then enter pulse at edge N -> grant_enter at N+1, L=0, occupancy=0001, capacity=3; door_open high 4 cycles; IDLE at N+6.
REQ-034 Four spaced enter pulses -> L=0,1,2,3, full=1, capacity=0; a fifth enter -> reject_enter pulse, occupancy stays 1111.
REQ-035 Full lot: exit with switch=01 -> grant_exit, L=1, occupancy=1101, capacity=1; a later exit with switch=01 -> reject_exit.
REQ-036 Full lot: enter and exit(switch=10) pulsed in the same cycle -> exit served first (occupancy=1011), then enter served with L=2 (occupancy=1111); no reject.
REQ-037 Lot half full, enter and valid exit pending together, twice -> grant order alternates exit, enter, exit, enter.
REQ-038 RST asserted during OPEN_IN at timer=2 -> next edge door_open=0, occupancy=0000, capacity=4, pending flags clear.
